// File: rtl/mem_bridge_pkg.sv
// Shared types for the core-to-system-bus memory bridge.
// Access sizes and bridge FSM states.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DONE
    } mem_bridge_state_t;

endpackage

// File: rtl/mem_bridge_if.sv
// System bus side of the memory bridge: req/gnt/rvalid handshake.
interface mem_bridge_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

endinterface

// File: rtl/mem_bridge_lane_align.sv
// Byte-lane steering: enables, write replication, read extraction
// and alignment check from access size and the low address bits.
module mem_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = 32'h0;
        o_rdata      = 32'h0;
        o_misaligned = 1'b1;
        case (mem_size_t'(i_size))
            MEM_SIZE_BYTE: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wdata[7:0]}};
                o_rdata      = {24'h0, w_shifted[7:0]};
                o_misaligned = 1'b0;
            end
            MEM_SIZE_HALF: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {16'h0, w_shifted[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            MEM_SIZE_WORD: begin
                o_be         = 4'b1111;
                o_wdata      = i_wdata;
                o_rdata      = w_shifted;
                o_misaligned = |i_addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// Turns single-cycle core load/store requests into bus transactions,
// stalling the core until completion and flagging errors/timeouts.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         core_rd_req_i,
    input  logic         core_wr_req_i,
    input  logic [31:0]  core_addr_i,
    input  logic [1:0]   core_size_i,
    input  logic [31:0]  core_wdata_i,
    output logic [31:0]  core_rdata_o,
    output logic         stall_o,
    output logic         done_o,
    output logic         err_o,
    mem_bridge_if.master bus
);

    mem_bridge_state_t r_state, w_state_nxt;
    logic [31:0] r_addr, r_wdata, r_rdata, r_cnt;
    logic [1:0]  r_size;
    logic        r_we, r_err, w_err_nxt;
    logic        w_req_in, w_idle, w_req, w_wait, w_tmo;
    logic [1:0]  w_size, w_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes, w_rext;
    logic        w_misaligned;

    assign w_req_in = core_rd_req_i | core_wr_req_i;
    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = (r_state == S_REQ);
    assign w_wait   = (r_state == S_WAIT_R);
    // In IDLE the aligner checks the incoming request; afterwards the latched one
    assign w_size   = w_idle ? core_size_i : r_size;
    assign w_lo     = w_idle ? core_addr_i[1:0] : r_addr[1:0];
    assign w_tmo    = (TIMEOUT_CYCLES != 32'd0) &&
                      (r_cnt == TIMEOUT_CYCLES - 32'd1);

    mem_lane_align u_align (
        .i_size       (w_size),
        .i_addr_lo    (w_lo),
        .i_wdata      (r_wdata),
        .i_rdata      (bus.bus_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wlanes),
        .o_rdata      (w_rext),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_req_in) begin
                    w_state_nxt = w_misaligned ? S_DONE : S_REQ;
                    w_err_nxt   = w_misaligned;
                end
            end
            S_REQ: begin
                if (bus.bus_gnt_i) begin
                    if (r_we) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = bus.bus_err_i;
                    end else begin
                        w_state_nxt = S_WAIT_R;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_WAIT_R: begin
                if (bus.bus_rvalid_i) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = bus.bus_err_i;
                end else if (w_tmo) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_cnt   <= 32'h0;
            r_size  <= 2'b00;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_idle && w_req_in) begin
                r_addr  <= core_addr_i;
                r_size  <= core_size_i;
                r_wdata <= core_wdata_i;
                r_we    <= core_wr_req_i;
            end
            if (w_state_nxt == S_REQ && !w_req)
                r_cnt <= 32'h0;
            else if (w_req || w_wait)
                r_cnt <= r_cnt + 32'd1;
            if (w_wait && bus.bus_rvalid_i && !bus.bus_err_i)
                r_rdata <= w_rext;
        end
    end

    assign core_rdata_o    = r_rdata;
    assign done_o          = (r_state == S_DONE);
    assign err_o           = done_o & r_err;
    assign stall_o         = w_req_in & (r_state != S_DONE);

    assign bus.bus_req_o   = w_req;
    assign bus.bus_we_o    = w_req & r_we;
    assign bus.bus_addr_o  = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.bus_be_o    = w_req ? w_be : 4'b0000;
    assign bus.bus_wdata_o = w_req ? w_wlanes : 32'h0;

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed scenarios plus
// randomized accesses against a byte-lane reference model.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        core_rd_req, core_wr_req;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [1:0]  core_size;
    logic        stall_o, done_o, err_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata = 32'h0;

    mem_bridge_if bus();

    mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .core_rd_req_i(core_rd_req),
        .core_wr_req_i(core_wr_req),
        .core_addr_i  (core_addr),
        .core_size_i  (core_size),
        .core_wdata_i (core_wdata),
        .core_rdata_o (core_rdata),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_k;
        bit          err;
        int          req_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          we;
        logic [31:0] rdata;
        bit          stall_ok;
        bit          stable;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int nbytes(logic [1:0] sz);
        case (sz)
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_mis(logic [1:0] sz, logic [31:0] a);
        int n = nbytes(sz);
        if (n == 0) return 1'b1;
        return (int'(a % 4) % n) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] sz, logic [31:0] a);
        int n = nbytes(sz);
        int off = int'(a % 4);
        logic [3:0] b = 4'b0;
        for (int i = 0; i < 4; i++)
            b[i] = (i >= off) && (i < off + n);
        return b;
    endfunction

    function automatic logic [31:0] m_wd(logic [1:0] sz, logic [31:0] wd);
        int n = nbytes(sz);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(logic [1:0] sz, logic [31:0] a,
                                         logic [31:0] rd);
        int n = nbytes(sz);
        longint v = longint'(rd) >> (8 * int'(a % 4));
        longint mask = (longint'(1) << (8 * n)) - 1;
        return 32'(v & mask);
    endfunction

    // ---------------- bus/core driver ----------------
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd,
                          input int gd, input int rvd,
                          input logic [31:0] rdat, input bit berr,
                          output obs_t o);
        bit granted = 0;
        int wk = 0;
        o.done_k = 0; o.err = 0; o.req_cycles = 0; o.addr = 0; o.be = 0;
        o.wdata = 0; o.we = 0; o.rdata = 0; o.stall_ok = 1; o.stable = 1;
        @(negedge clk);
        core_rd_req = rd; core_wr_req = wr; core_addr = a;
        core_size = sz; core_wdata = wd;
        #1 if (!stall_o) o.stall_ok = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0; bus.bus_err_i = 0;
            if (done_o) begin
                o.done_k = k; o.err = err_o; o.rdata = core_rdata;
                if (stall_o) o.stall_ok = 0;
                break;
            end
            if (!stall_o) o.stall_ok = 0;
            if (bus.bus_req_o) begin
                if (o.req_cycles == 0) begin
                    o.addr = bus.bus_addr_o; o.be = bus.bus_be_o;
                    o.wdata = bus.bus_wdata_o; o.we = bus.bus_we_o;
                end else if (o.addr !== bus.bus_addr_o || o.be !== bus.bus_be_o ||
                             o.wdata !== bus.bus_wdata_o || o.we !== bus.bus_we_o) begin
                    o.stable = 0;
                end
                if (o.req_cycles == gd) begin
                    bus.bus_gnt_i = 1;
                    if (wr) bus.bus_err_i = berr;
                    granted = 1;
                end
                o.req_cycles++;
            end else if (granted) begin
                if (wk == rvd) begin
                    bus.bus_rvalid_i = 1; bus.bus_rdata_i = rdat; bus.bus_err_i = berr;
                end
                wk++;
            end
        end
        core_rd_req = 0; core_wr_req = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_i = 1;
        #1;
        checks++;
        if ({bus.bus_req_o, bus.bus_we_o, bus.bus_be_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_bus_ctl: got %b exp 0",
                     {bus.bus_req_o, bus.bus_we_o, bus.bus_be_o});
        end
        checks++;
        if ({bus.bus_addr_o, bus.bus_wdata_o} !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus_data: got %h exp 0",
                     {bus.bus_addr_o, bus.bus_wdata_o});
        end
        checks++;
        if ({core_rdata, stall_o, done_o, err_o} !== 35'h0) begin
            errors++;
            $display("FAIL reset_core: got %h exp 0",
                     {core_rdata, stall_o, done_o, err_o});
        end
        @(negedge clk);
        @(negedge clk);
        reset_i = 0;
    endtask

    task automatic test_word_read();
        obs_t o;
        access(1, 0, 32'h00010004, 2'd2, 32'h0, 0, 0, 32'hDEADBEEF, 0, o);
        exp_rdata = 32'hDEADBEEF;
        checks++;
        if (o.addr !== 32'h00010004) begin
            errors++; $display("FAIL wr_addr: got %h exp %h", o.addr, 32'h00010004);
        end
        checks++;
        if (o.be !== 4'b1111) begin
            errors++; $display("FAIL wr_be: got %b exp 1111", o.be);
        end
        checks++;
        if (o.rdata !== exp_rdata || o.err !== 1'b0) begin
            errors++; $display("FAIL wr_rdata: got %h/%0d exp %h/0", o.rdata, o.err, exp_rdata);
        end
        checks++;
        if (o.done_k != 3 || !o.stall_ok) begin
            errors++; $display("FAIL wr_timing: got done %0d stall_ok %0d exp 3/1",
                               o.done_k, o.stall_ok);
        end
    endtask

    task automatic test_byte_write();
        obs_t o;
        access(0, 1, 32'h00010003, 2'd0, 32'h000000A5, 0, 0, 32'h0, 0, o);
        checks++;
        if (o.be !== 4'b1000 || o.we !== 1'b1) begin
            errors++; $display("FAIL bw_be_we: got %b/%0d exp 1000/1", o.be, o.we);
        end
        checks++;
        if (o.wdata !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bw_wdata: got %h exp a5a5a5a5", o.wdata);
        end
        checks++;
        if (o.done_k != 2 || o.err !== 1'b0) begin
            errors++; $display("FAIL bw_done: got %0d/%0d exp 2/0", o.done_k, o.err);
        end
    endtask

    task automatic test_narrow_read();
        obs_t o;
        access(1, 0, 32'h00010002, 2'd1, 32'h0, 0, 0, 32'h12345678, 0, o);
        checks++;
        if (o.rdata !== 32'h00001234 || o.be !== 4'b1100) begin
            errors++; $display("FAIL half_read: got %h/%b exp 00001234/1100", o.rdata, o.be);
        end
        access(1, 0, 32'h00010001, 2'd0, 32'h0, 1, 1, 32'h12345678, 0, o);
        exp_rdata = 32'h00000056;
        checks++;
        if (o.rdata !== exp_rdata || o.done_k != 5) begin
            errors++; $display("FAIL byte_read: got %h/%0d exp 00000056/5", o.rdata, o.done_k);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        access(1, 0, 32'h00010002, 2'd2, 32'h0, 0, 0, 32'hFFFFFFFF, 0, o);
        checks++;
        if (o.req_cycles != 0 || o.done_k != 1 || o.err !== 1'b1) begin
            errors++; $display("FAIL misaligned: got req %0d done %0d err %0d exp 0/1/1",
                               o.req_cycles, o.done_k, o.err);
        end
        checks++;
        if (o.rdata !== exp_rdata) begin
            errors++; $display("FAIL misaligned_rdata: got %h exp %h", o.rdata, exp_rdata);
        end
        access(0, 1, 32'h00010000, 2'd3, 32'h1, 0, 0, 32'h0, 0, o);
        checks++;
        if (o.req_cycles != 0 || o.err !== 1'b1) begin
            errors++; $display("FAIL size3: got req %0d err %0d exp 0/1", o.req_cycles, o.err);
        end
    endtask

    task automatic test_timeout_reset();
        obs_t o;
        bit bad = 0;
        access(1, 0, 32'h00010010, 2'd2, 32'h0, 100, 0, 32'h0, 0, o);
        checks++;
        if (o.req_cycles != 4 || o.done_k != 5 || o.err !== 1'b1) begin
            errors++; $display("FAIL timeout: got req %0d done %0d err %0d exp 4/5/1",
                               o.req_cycles, o.done_k, o.err);
        end
        @(negedge clk);
        core_rd_req = 1; core_addr = 32'h00010008; core_size = 2'd2;
        @(negedge clk);
        checks++;
        if (bus.bus_req_o !== 1'b1) begin
            errors++; $display("FAIL rst_pre_req: got %0d exp 1", bus.bus_req_o);
        end
        #2 reset_i = 1; core_rd_req = 0;
        #1;
        exp_rdata = 32'h0;
        checks++;
        if ({bus.bus_req_o, bus.bus_we_o, bus.bus_be_o, bus.bus_addr_o,
             bus.bus_wdata_o, core_rdata, stall_o, done_o, err_o} !== 105'h0) begin
            errors++; $display("FAIL rst_mid: got req %0d rdata %h exp all 0",
                               bus.bus_req_o, core_rdata);
        end
        @(negedge clk);
        reset_i = 0; bus.bus_gnt_i = 1;
        @(negedge clk);
        bus.bus_gnt_i = 0; bus.bus_rvalid_i = 1; bus.bus_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        bus.bus_rvalid_i = 0;
        for (int i = 0; i < 3; i++) begin
            if (done_o || bus.bus_req_o) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad || core_rdata !== exp_rdata) begin
            errors++; $display("FAIL rst_stale: got bad %0d rdata %h exp 0/%h",
                               bad, core_rdata, exp_rdata);
        end
    endtask

    task automatic test_rd_wr_both();
        obs_t o;
        access(1, 1, 32'h00010020, 2'd2, 32'hCAFEF00D, 0, 0, 32'h0, 0, o);
        checks++;
        if (o.we !== 1'b1 || o.wdata !== 32'hCAFEF00D || o.done_k != 2) begin
            errors++; $display("FAIL rdwr: got we %0d wd %h done %0d exp 1/cafef00d/2",
                               o.we, o.wdata, o.done_k);
        end
    endtask

    task automatic test_bus_err();
        obs_t o;
        access(1, 0, 32'h00010000, 2'd2, 32'h0, 0, 1, 32'h55555555, 1, o);
        checks++;
        if (o.err !== 1'b1 || o.rdata !== exp_rdata) begin
            errors++; $display("FAIL rd_berr: got err %0d rdata %h exp 1/%h",
                               o.err, o.rdata, exp_rdata);
        end
        access(0, 1, 32'h00010004, 2'd1, 32'h1234, 1, 0, 32'h0, 1, o);
        checks++;
        if (o.err !== 1'b1 || o.done_k != 3) begin
            errors++; $display("FAIL wr_berr: got err %0d done %0d exp 1/3", o.err, o.done_k);
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int it = 0; it < 60; it++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rdat = $urandom;
            int op = $urandom_range(0, 2);
            bit rd = (op != 1);
            bit wr = (op != 0);
            int gd = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(0, 2);
            int rvd = (gd <= 2) ? $urandom_range(0, 2 - gd) : 0;
            bit berr = ($urandom_range(0, 5) == 0);
            bit mis = m_mis(sz, a);
            bit tmo = !mis && gd >= 4;
            bit e_err = mis || tmo || berr;
            int e_done = mis ? 1 : tmo ? 5 : wr ? gd + 2 : gd + rvd + 3;
            int e_req = mis ? 0 : tmo ? 4 : gd + 1;
            access(rd, wr, a, sz, wd, gd, rvd, rdat, berr, o);
            if (!wr && !e_err) exp_rdata = m_rd(sz, a, rdat);
            checks++;
            if (o.done_k != e_done || o.err !== e_err || o.req_cycles != e_req) begin
                errors++; $display("FAIL rnd%0d_ctl: got d%0d e%0d r%0d exp d%0d e%0d r%0d",
                                   it, o.done_k, o.err, o.req_cycles, e_done, e_err, e_req);
            end
            checks++;
            if (o.rdata !== exp_rdata || !o.stall_ok) begin
                errors++; $display("FAIL rnd%0d_rdata: got %h stall_ok %0d exp %h/1",
                                   it, o.rdata, o.stall_ok, exp_rdata);
            end
            if (e_req > 0) begin
                checks++;
                if (o.addr !== {a[31:2], 2'b00} || o.be !== m_be(sz, a) ||
                    o.wdata !== m_wd(sz, wd) || o.we !== wr || !o.stable) begin
                    errors++; $display("FAIL rnd%0d_bus: got %h %b %h %0d s%0d exp %h %b %h %0d s1",
                                       it, o.addr, o.be, o.wdata, o.we, o.stable,
                                       {a[31:2], 2'b00}, m_be(sz, a), m_wd(sz, wd), wr);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        core_rd_req = 0; core_wr_req = 0; core_addr = 0;
        core_size = 0; core_wdata = 0;
        bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0;
        bus.bus_rdata_i = 0; bus.bus_err_i = 0;
        test_reset();
        test_word_read();
        test_byte_write();
        test_narrow_read();
        test_misaligned();
        test_timeout_reset();
        test_rd_wr_both();
        test_bus_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
